// File: rtl/meta_op_handler.sv
// rtl/meta_op_handler.sv - meta G-code handler: NOP, pen up/down with servo settle, and dwell timing.
// Runs only on clk_en ticks; never moves X/Y and never issues position updates.
module meta_op_handler #(
  parameter int ARG_W          = 16,
  parameter int TICKS_PER_UNIT = 1000,
  parameter int SETTLE_TICKS   = 200,
  parameter int PULSE_NUM_W    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   trigger,
  input  logic [1:0]             op_sel,
  input  logic [ARG_W-1:0]       arg,
  output logic                   rdy,
  output logic                   done,
  output logic [PULSE_NUM_W-1:0] motors_pulse_num_x,
  output logic [PULSE_NUM_W-1:0] motors_pulse_num_y,
  output logic                   motors_servo_pos,
  output logic                   motors_trigger,
  input  logic                   motors_rdy,
  input  logic                   motors_done,
  output logic [PULSE_NUM_W-1:0] pos_new_x,
  output logic [PULSE_NUM_W-1:0] pos_new_y,
  output logic                   pos_update
);

  localparam int TICK_W   = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam int SETTLE_W = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;

  localparam logic [TICK_W-1:0]   TICK_LOAD   = TICK_W'(TICKS_PER_UNIT - 1);
  localparam logic [TICK_W-1:0]   TICK_ONE    = TICK_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = (SETTLE_TICKS > 0) ? SETTLE_W'(SETTLE_TICKS - 1) : '0;
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
  localparam logic [ARG_W-1:0]    UNIT_ONE    = ARG_W'(1);

  localparam logic [1:0] OP_NOP      = 2'd0;
  localparam logic [1:0] OP_PEN_UP   = 2'd1;
  localparam logic [1:0] OP_PEN_DOWN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVO_TRIG,
    S_SERVO_WAIT,
    S_SETTLE,
    S_DWELL,
    S_DONE
  } state_t;

  state_t              state;
  logic                pen;
  logic                pen_target;
  logic [TICK_W-1:0]   tick_cnt;
  logic [ARG_W-1:0]    unit_cnt;
  logic [SETTLE_W-1:0] settle_cnt;

  assign pen_target = (op_sel == OP_PEN_DOWN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      pen            <= 1'b0;
      tick_cnt       <= '0;
      unit_cnt       <= '0;
      settle_cnt     <= '0;
      motors_trigger <= 1'b0;
    end else if (clk_en) begin
      motors_trigger <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            case (op_sel)
              OP_NOP: state <= S_DONE;
              OP_PEN_UP, OP_PEN_DOWN: begin
                // Pen already where asked: finish without touching the motors.
                if (pen_target == pen) begin
                  state <= S_DONE;
                end else begin
                  pen   <= pen_target;
                  state <= S_SERVO_TRIG;
                end
              end
              default: begin
                if (arg == '0) begin
                  state <= S_DONE;
                end else begin
                  unit_cnt <= arg;
                  tick_cnt <= TICK_LOAD;
                  state    <= S_DWELL;
                end
              end
            endcase
          end
        end
        S_SERVO_TRIG: begin
          if (motors_rdy) begin
            motors_trigger <= 1'b1;
            state          <= S_SERVO_WAIT;
          end
        end
        S_SERVO_WAIT: begin
          if (motors_done) begin
            if (SETTLE_TICKS == 0) begin
              state <= S_DONE;
            end else begin
              settle_cnt <= SETTLE_LOAD;
              state      <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_DONE;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_ONE;
          end
        end
        S_DWELL: begin
          // Prescaled down-count: arg units of TICKS_PER_UNIT ticks, no multiply.
          if (tick_cnt == '0) begin
            if (unit_cnt == UNIT_ONE) begin
              unit_cnt <= '0;
              state    <= S_DONE;
            end else begin
              unit_cnt <= unit_cnt - UNIT_ONE;
              tick_cnt <= TICK_LOAD;
            end
          end else begin
            tick_cnt <= tick_cnt - TICK_ONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rdy                = (state == S_IDLE);
  assign done               = (state == S_DONE);
  assign motors_servo_pos   = pen;
  assign motors_pulse_num_x = '0;
  assign motors_pulse_num_y = '0;
  assign pos_new_x          = '0;
  assign pos_new_y          = '0;
  assign pos_update         = 1'b0;

endmodule

// File: tb/tb_meta_op_handler.sv
// tb/tb_meta_op_handler.sv - scoreboard bench for meta_op_handler with a small motors-block model.
module tb_meta_op_handler;

  localparam int ARG_W  = 16;
  localparam int TPU    = 4;
  localparam int SETTLE = 3;
  localparam int PW     = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clk_en = 1'b1;
  logic             trigger = 1'b0;
  logic [1:0]       op_sel = 2'd0;
  logic [ARG_W-1:0] arg = '0;
  logic             rdy, done;
  logic [PW-1:0]    motors_pulse_num_x, motors_pulse_num_y, pos_new_x, pos_new_y;
  logic             motors_servo_pos, motors_trigger, pos_update;
  logic             motors_rdy = 1'b1;
  logic             motors_done = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int tick_no = 0;
  int trig_count = 0;
  int done_count = 0;
  int mot_due = -100;
  int mot_delay = 5;
  int en_div = 1;
  int cyc_cnt = 0;
  logic en_at_edge = 1'b0;
  logic done_prev = 1'b0;
  logic trig_prev = 1'b0;
  logic force_mdone = 1'b0;
  logic exp_pen = 1'b0;

  string sb_tag[$];
  int    sb_tick[$];
  string pop_tag;
  int    pop_tick;

  always #5 clk = ~clk;

  meta_op_handler #(
    .ARG_W(ARG_W), .TICKS_PER_UNIT(TPU), .SETTLE_TICKS(SETTLE), .PULSE_NUM_W(PW)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger), .op_sel(op_sel), .arg(arg),
    .rdy(rdy), .done(done),
    .motors_pulse_num_x(motors_pulse_num_x), .motors_pulse_num_y(motors_pulse_num_y),
    .motors_servo_pos(motors_servo_pos), .motors_trigger(motors_trigger),
    .motors_rdy(motors_rdy), .motors_done(motors_done),
    .pos_new_x(pos_new_x), .pos_new_y(pos_new_y), .pos_update(pos_update)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // clk_en pattern: every cycle, or one cycle in two
  initial forever begin
    @(posedge clk);
    #1;
    cyc_cnt++;
    clk_en = (en_div == 1) || (cyc_cnt % 2 == 0);
  end

  // monitor + scoreboard pop + motors model, evaluated just after each enabled edge
  initial forever begin
    @(posedge clk);
    en_at_edge = clk_en;
    #1;
    if (en_at_edge) begin
      tick_no++;
      if (done) begin
        done_count++;
        check("done_one_tick", done_prev, 0);
        if (sb_tick.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          pop_tag  = sb_tag.pop_front();
          pop_tick = sb_tick.pop_front();
          check(pop_tag, tick_no, pop_tick);
        end
      end
      if (motors_trigger) begin
        trig_count++;
        check("mtrig_one_tick", trig_prev, 0);
        mot_due = tick_no + mot_delay;
      end
      done_prev   = done;
      trig_prev   = motors_trigger;
      motors_done = (tick_no == mot_due - 1) || force_mdone;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic tick();
    do cyc(); while (!en_at_edge);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic issue(input logic [1:0] op, input logic [ARG_W-1:0] a, input int lat, input string tag);
    int g = 0;
    while (!rdy && g < 2000) begin
      cyc();
      g++;
    end
    check({tag, "_rdy"}, rdy, 1);
    op_sel  = op;
    arg     = a;
    trigger = 1'b1;
    sb_tag.push_back(tag);
    sb_tick.push_back(tick_no + 1 + lat);
    tick();
    trigger = 1'b0;
    arg     = '1;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while ((sb_tick.size() != 0 || !rdy) && g < 5000) begin
      cyc();
      g++;
    end
    check({tag, "_idle"}, (g < 5000), 1);
    check({tag, "_pen"}, motors_servo_pos, exp_pen);
  endtask

  task automatic async_reset_check(input string tag);
    #3;
    reset = 1'b0;
    #1;
    check({tag, "_rdy"}, rdy, 1);
    check({tag, "_done"}, done, 0);
    check({tag, "_servo"}, motors_servo_pos, 0);
    check({tag, "_mtrig"}, motors_trigger, 0);
    sb_tag.delete();
    sb_tick.delete();
    exp_pen = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    ticks(2);
  endtask

  initial begin
    int k;
    int dc;
    int a0;
    repeat (3) cyc();
    check("rst_rdy", rdy, 1);
    check("rst_done", done, 0);
    check("rst_mtrig", motors_trigger, 0);
    check("rst_servo", motors_servo_pos, 0);
    reset = 1'b1;
    ticks(2);

    issue(2'd0, 16'h1234, 0, "nop");
    wait_idle("nop");
    check("nop_no_mtrig", trig_count, 0);

    motors_rdy = 1'b1;
    exp_pen    = 1'b1;
    issue(2'd2, 16'd0, 1 + 5 + SETTLE, "pen_down");
    check("pd_servo_at_accept", motors_servo_pos, 1);
    check("pd_mtrig_not_yet", motors_trigger, 0);
    wait_idle("pen_down");
    check("pd_one_mtrig", trig_count, 1);

    issue(2'd2, 16'd0, 0, "pen_fast");
    wait_idle("pen_fast");
    check("pf_no_mtrig", trig_count, 1);

    en_div = 2;
    ticks(2);
    issue(2'd3, 16'd3, 3 * TPU, "dwell3");
    k = 0;
    while (!done && k < 200) begin
      cyc();
      k++;
    end
    check("dwell3_clk_cycles", k, 24);
    wait_idle("dwell3");
    issue(2'd3, 16'd0, 0, "dwell0");
    wait_idle("dwell0");
    en_div = 1;
    ticks(2);

    motors_rdy = 1'b0;
    exp_pen    = 1'b0;
    issue(2'd1, 16'd0, 10 + 1 + 5 + SETTLE, "pen_up_wait");
    check("pu_servo_at_accept", motors_servo_pos, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("pu_hold_mtrig", motors_trigger, 0);
    end
    motors_rdy = 1'b1;
    wait_idle("pen_up_wait");
    check("pu_one_mtrig", trig_count, 2);

    dc = done_count;
    force_mdone = 1'b1;
    ticks(3);
    force_mdone = 1'b0;
    ticks(2);
    check("spur_rdy", rdy, 1);
    check("spur_no_mtrig", trig_count, 2);
    check("spur_no_done", done_count - dc, 0);

    dc = done_count;
    op_sel  = 2'd3;
    arg     = 16'd2;
    trigger = 1'b1;
    a0 = tick_no + 1;
    sb_tag.push_back("cont_first");
    sb_tick.push_back(a0 + 2 * TPU);
    sb_tag.push_back("cont_second");
    sb_tick.push_back(a0 + 2 * TPU + 2 + 2 * TPU);
    k = 0;
    while (tick_no < a0 + 2 * TPU + 2 && k < 200) begin
      tick();
      k++;
      if (tick_no == a0 + 2 * TPU) check("cont_rdy_low_in_done", rdy, 0);
      if (tick_no == a0 + 2 * TPU + 1) begin
        check("cont_single_done", done_count - dc, 1);
        check("cont_rdy_back", rdy, 1);
      end
    end
    trigger = 1'b0;
    wait_idle("cont");
    check("cont_two_dones", done_count - dc, 2);

    issue(2'd3, 16'd5, 5 * TPU, "dwell_abort");
    ticks(5);
    async_reset_check("rst_dwell");

    mot_delay  = 50;
    motors_rdy = 1'b1;
    issue(2'd2, 16'd0, 1 + 50 + SETTLE, "pd_abort");
    ticks(5);
    check("pda_pen_down", motors_servo_pos, 1);
    async_reset_check("rst_servo_wait");
    mot_delay = 5;

    issue(2'd0, 16'd0, 0, "nop_after_rst");
    wait_idle("nop_after_rst");
    check("const_px", motors_pulse_num_x, 0);
    check("const_py", motors_pulse_num_y, 0);
    check("const_nx", pos_new_x, 0);
    check("const_ny", pos_new_y, 0);
    check("const_upd", pos_update, 0);
    ticks(5);
    check("sb_empty", sb_tick.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/meta_op_handler.md
Name: meta_op_handler

Overview:
Parametrised handler for meta G-codes that do not move the X/Y steppers: NOP, pen-up, pen-down and dwell (G4). It sits beside the motion op handlers behind the processor's opcode-handler handshake. It drives the motors-control bus with zero pulse counts, sequences servo moves with a settle delay, and times dwells in clk_en ticks. It never issues position updates.

Parameters:
ARG_W, 16, width of the dwell argument (dwell units).
TICKS_PER_UNIT, 1000, clk_en ticks per dwell unit; must be >= 1.
SETTLE_TICKS, 200, clk_en ticks waited after a servo move completes; 0 means no settle.
PULSE_NUM_W, 16, width of the motors pulse-count outputs.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
clk_en  in  1  tick enable; FSM and counters advance only on clk_en=1 cycles
trigger  in  1  handler start, from the parser side
op_sel  in  2  0=NOP, 1=PEN_UP, 2=PEN_DOWN, 3=DWELL; sampled with trigger
arg  in  ARG_W  dwell units; sampled with trigger; ignored unless op_sel=3
rdy  out  1  handler idle and able to accept a trigger
done  out  1  operation complete
motors_pulse_num_x  out  PULSE_NUM_W  constant 0
motors_pulse_num_y  out  PULSE_NUM_W  constant 0
motors_servo_pos  out  1  held pen position (0=UP, 1=DOWN)
motors_trigger  out  1  start request to the motors block
motors_rdy  in  1  motors block idle
motors_done  in  1  motors block finished
pos_new_x  out  PULSE_NUM_W  constant 0
pos_new_y  out  PULSE_NUM_W  constant 0
pos_update  out  1  constant 0

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; pen register UP; all counters 0.
  - Output values during reset: rdy=1, done=0, motors_trigger=0, motors_servo_pos=UP.
  - Reset mid-operation aborts immediately; no done is produced.
- State changes occur only on rising clk edges with clk_en=1. All outputs are registered or decoded from state and hold between ticks.
- States: IDLE, SERVO_TRIG, SERVO_WAIT, SETTLE, DWELL, DONE.
- IDLE:
  - rdy=1.
  - On a tick with trigger=1, latch op_sel and arg, then branch:
    - NOP -> DONE.
    - PEN_UP or PEN_DOWN with target equal to the pen register -> DONE (fast path, motors untouched).
    - PEN_UP or PEN_DOWN with a different target -> load the pen register with the target, go to SERVO_TRIG.
    - DWELL with arg=0 -> DONE.
    - DWELL with arg>0 -> load unit_cnt=arg and tick_cnt=TICKS_PER_UNIT-1, go to DWELL.
- SERVO_TRIG:
  - Wait until motors_rdy=1.
  - On that tick motors_trigger=1 for exactly one tick, then go to SERVO_WAIT.
- SERVO_WAIT:
  - On a tick with motors_done=1, go to SETTLE with settle_cnt=SETTLE_TICKS-1.
  - If SETTLE_TICKS=0, go directly to DONE instead.
- SETTLE: decrement settle_cnt each tick; at 0, go to DONE.
- DWELL:
  - Prescaler: tick_cnt decrements each tick.
  - When tick_cnt=0: decrement unit_cnt and reload tick_cnt.
  - When unit_cnt reaches 0 (on the tick_cnt=0 tick where unit_cnt=1), go to DONE.
  - Total time in DWELL is exactly arg*TICKS_PER_UNIT ticks. No multiplier is used.
- DONE:
  - done=1, rdy=0, for exactly one tick, then IDLE.
- rdy=0 in every state except IDLE.
- trigger in a non-IDLE state is ignored and not queued.
- motors_done outside SERVO_WAIT is ignored.
- motors_servo_pos always equals the pen register. It changes on the accept tick, before motors_trigger.
- NOP latency: accept at tick n, done at tick n+1, rdy=1 again at tick n+2.
- Counter widths:
  - tick_cnt: clog2(TICKS_PER_UNIT), minimum 1.
  - unit_cnt: ARG_W.
  - settle_cnt: clog2(SETTLE_TICKS+1).
  - A maximum arg (all ones) must not overflow.

Test Plan:
- Reset, then NOP trigger with clk_en every cycle -> rdy=1 after reset; done high exactly 1 cycle, one tick after accept; motors_trigger never asserted.
- PEN_DOWN from UP, motors_rdy=1, motors_done returned 5 ticks after motors_trigger, SETTLE_TICKS=3 -> servo_pos=1 from the accept tick; single motors_trigger pulse; done exactly 5+3+1 ticks after the trigger pulse. Then repeat PEN_DOWN -> fast path, done 1 tick after accept, no motors_trigger.
- DWELL arg=3, TICKS_PER_UNIT=4, clk_en 1-in-2 cycles -> done asserted after exactly 12 enabled ticks (24 clk cycles); DWELL arg=0 -> done 1 tick after accept.
- PEN_UP with motors_rdy=0 for 10 ticks -> stays in SERVO_TRIG, motors_trigger=0 until motors_rdy=1, then a one-tick pulse; spurious motors_done while IDLE is ignored.
- Trigger asserted continuously during a DWELL arg=2 -> only one done; a new op is accepted only in the cycle after rdy returns to 1.
- Async reset asserted mid-DWELL and mid-SERVO_WAIT -> immediate IDLE, rdy=1, done=0, servo_pos=UP, with no clock edge required.
